branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have a single clock and an asynchronous active-high reset, listed first: clk  in  1  rising-edge clock; clr  in  1  async active-high reset.
REQ-002 SHALL have run  in  1  level; sequencing is permitted while high.
REQ-003 SHALL have mem_ready  in  1  memory read data valid this cycle.
REQ-004 SHALL have IR  in  32  instruction register contents.
REQ-005 SHALL have CON  in  1  registered branch-condition flag from the condition flip-flop.
REQ-006 SHALL have these 1-bit control outputs: PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD.
REQ-007 SHALL have c2  out  2  condition select, equal to IR[20:19].
REQ-008 SHALL have state  out  3  current step, T0..T6 encoded 0..6.
REQ-009 SHALL have illegal_op  out  1  one-cycle pulse on a non-branch opcode.
REQ-010 SHALL have taken_cnt and not_taken_cnt  out  16 each  branch statistics.

Function
REQ-011 SHALL implement states T0-T6; all control outputs are Moore outputs decoded from state, except PCin in T1 and T6 as stated below.
REQ-012 T0: assert PCout, MARin, IncPC, Zin; advance to T1 when run=1; otherwise hold T0 with all controls 0.
REQ-013 T1: assert Zlowout, Read, MDRin; assert PCin on the first T1 cycle only; hold T1 until mem_ready=1, then go to T2.
REQ-014 T2: assert MDRout, IRin; go to T3.
REQ-015 T3: decode IR[31:27]; if 5'b10010 (branch), assert Gra, Rout, CONin and go to T4; otherwise assert illegal_op for one cycle, no other controls, and return to T0.
REQ-016 T4: assert PCout, Yin; go to T5.
REQ-017 T5: assert Cout, ADD, Zin; go to T6.
REQ-018 T6: assert Zlowout; PCin = CON; go to T0.
REQ-019 In T6, SHALL increment taken_cnt when CON=1 and not_taken_cnt when CON=0; each counter saturates at 16'hFFFF and never wraps.
REQ-020 run is sampled only in T0; deasserting run mid-instruction SHALL NOT abort the instruction.
REQ-021 mem_ready is ignored outside T1; mem_ready high on T1 entry SHALL give a one-cycle T1.
REQ-022 c2 is combinational from IR and valid in every state.
REQ-023 Branch latency SHALL be 7 cycles from leaving T0 to returning to T0 when mem_ready=1 in the first T1 cycle, plus one cycle per T1 stall; illegal opcode latency SHALL be 4 cycles.
REQ-024 Unused state encoding 7 SHALL return to T0 on the next edge with all controls 0.

Reset
REQ-025 clr=1 SHALL force state=T0, both counters=0, and illegal_op=0 immediately, independent of clk.
REQ-026 While clr=1 all control outputs SHALL be 0, including T0 controls.
REQ-027 clr asserted mid-instruction SHALL abandon the instruction; after clr falls, sequencing restarts at T0 on the first edge with run=1.

Structure
REQ-028 A shared package SHALL hold the state encoding constants T0..T6, the branch opcode 5'b10010, and the counter width 16.
REQ-029 One sub-module is natural: sat_counter16 (enable, clr, count, saturation), instantiated twice.
REQ-030 No memory or datapath logic SHALL reside in this block; it only sequences and consumes CON.

Verification
REQ-031 Reset: clr=1 mid-T4 -> state=0 and all controls 0 at once; counters=0.
REQ-032 Taken branch: run=1, mem_ready=1, IR=32'h9000_0000, CON=1 at T6 -> PCin=1 in T6; taken_cnt=1; back to T0 after 7 cycles.
REQ-033 Not-taken branch: same IR with CON=0 -> PCin=0 in T6; not_taken_cnt=1; c2=2'b00 throughout.
REQ-034 Memory stall: mem_ready low for 3 cycles in T1 -> T1 lasts 4 cycles; PCin high only in the first; Read held high throughout.
REQ-035 Illegal opcode: IR=32'h0800_0000 -> illegal_op single pulse in T3; CONin never asserted; T0 follows.
REQ-036 Saturation: preload taken_cnt to 16'hFFFE, run 3 taken branches -> value stays 16'hFFFF.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer.
//   state_t    : step encoding T0..T6 (3 bits, value 7 unused)
//   BRANCH_OP  : IR[31:27] value identifying a conditional branch
//   CNT_W      : width of the branch statistics counters
package branch_sequencer_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } state_t;

  localparam logic [4:0] BRANCH_OP = 5'b10010;
  localparam int         CNT_W     = 16;

endpackage

// File: rtl/branch_sequencer_sat.sv
// Saturating up-counter used for the branch statistics.
// Ports:
//   clk   : rising-edge clock
//   clr   : asynchronous active-high clear (count -> 0)
//   en    : count up by one this cycle
//   count : current value; sticks at all-ones, never wraps
module sat_counter16
  import branch_sequencer_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Control-step sequencer for the conditional-branch instruction.
// Walks T0..T6, decoding the control strobes for each step; a non-branch
// opcode at T3 pulses illegal_op and returns to T0. Counts taken and
// not-taken branches with saturating 16-bit counters.
// Ports:
//   clk, clr          : clock, asynchronous active-high reset
//   run               : sequencing permitted (sampled in T0 only)
//   mem_ready         : memory read data valid (looked at in T1 only)
//   IR                : instruction register contents
//   CON               : branch condition flag (consumed in T6)
//   PCout..ADD        : control strobes
//   c2                : condition select, IR[20:19]
//   state             : current step 0..6
//   illegal_op        : pulse in T3 for a non-branch opcode
//   taken_cnt         : number of taken branches (saturating)
//   not_taken_cnt     : number of not-taken branches (saturating)
module branch_sequencer
  import branch_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      IR,
  input  logic             CON,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic [1:0]       c2,
  output logic [2:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  state_t state_q;
  // High only during the first cycle spent in T1, so PCin is not
  // repeated while a memory read stalls.
  logic   t1_first;
  logic   is_branch;
  logic   taken_en;
  logic   not_taken_en;

  // Only the opcode and condition-select fields matter here.
  logic   unused_ir;
  assign unused_ir = ^{IR[26:21], IR[18:0]};

  assign is_branch = (IR[31:27] == BRANCH_OP);
  assign c2        = IR[20:19];
  assign state     = state_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= T0;
      t1_first <= 1'b0;
    end else begin
      t1_first <= 1'b0;
      case (state_q)
        T0: begin
          if (run) begin
            state_q  <= T1;
            t1_first <= 1'b1;
          end
        end
        T1:      if (mem_ready) state_q <= T2;
        T2:      state_q <= T3;
        T3:      state_q <= is_branch ? T4 : T0;
        T4:      state_q <= T5;
        T5:      state_q <= T6;
        T6:      state_q <= T0;
        default: state_q <= T0;
      endcase
    end
  end

  // Strobes are decoded from the current step; clr masks everything so
  // nothing is driven while reset is held, T0 strobes included.
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Rout       = 1'b0;
    CONin      = 1'b0;
    Yin        = 1'b0;
    Cout       = 1'b0;
    ADD        = 1'b0;
    illegal_op = 1'b0;
    if (!clr) begin
      case (state_q)
        T0: begin
          PCout = run;
          MARin = run;
          IncPC = run;
          Zin   = run;
        end
        T1: begin
          Zlowout = 1'b1;
          Read    = 1'b1;
          MDRin   = 1'b1;
          PCin    = t1_first;
        end
        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        T3: begin
          if (is_branch) begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            CONin = 1'b1;
          end else begin
            illegal_op = 1'b1;
          end
        end
        T4: begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
        T5: begin
          Cout = 1'b1;
          ADD  = 1'b1;
          Zin  = 1'b1;
        end
        T6: begin
          Zlowout = 1'b1;
          PCin    = CON;
        end
        default: ;
      endcase
    end
  end

  assign taken_en     = (state_q == T6) && CON;
  assign not_taken_en = (state_q == T6) && !CON;

  sat_counter16 #(.W(CNT_W)) u_taken (
    .clk   (clk),
    .clr   (clr),
    .en    (taken_en),
    .count (taken_cnt)
  );

  sat_counter16 #(.W(CNT_W)) u_not_taken (
    .clk   (clk),
    .clr   (clr),
    .en    (not_taken_en),
    .count (not_taken_cnt)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Testbench for branch_sequencer. Each instruction is expanded into its
// expected per-cycle trace (step number, strobes, c2, illegal_op and the
// statistics counters) as it is driven; a monitor compares every cycle.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] IR = '0;
  logic        CON = 1'b0;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD;
  logic [1:0]  c2;
  logic [2:0]  state;
  logic        illegal_op;
  logic [15:0] taken_cnt, not_taken_cnt;

  branch_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .IR(IR), .CON(CON),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .Yin(Yin), .Cout(Cout), .ADD(ADD),
    .c2(c2), .state(state), .illegal_op(illegal_op),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  always #5 clk = ~clk;

  // Strobe word order: PCout MARin IncPC Zin Zlowout PCin Read MDRin
  //                    MDRout IRin Gra Rout CONin Yin Cout ADD
  localparam logic [15:0] S_T0   = 16'hF000;  // PCout MARin IncPC Zin
  localparam logic [15:0] S_T1   = 16'h0B00;  // Zlowout Read MDRin
  localparam logic [15:0] S_PCIN = 16'h0400;
  localparam logic [15:0] S_T2   = 16'h00C0;  // MDRout IRin
  localparam logic [15:0] S_T3   = 16'h0038;  // Gra Rout CONin
  localparam logic [15:0] S_T4   = 16'h8004;  // PCout Yin
  localparam logic [15:0] S_T5   = 16'h1003;  // Cout ADD Zin
  localparam logic [15:0] S_T6   = 16'h0800;  // Zlowout
  localparam logic [4:0]  BR     = 5'b10010;

  typedef logic [53:0] vec_t;  // {state, strobes, c2, illegal_op, taken, not_taken}

  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_tk = 0;
  int   m_nt = 0;

  function automatic vec_t actual();
    return {state,
            PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
            MDRout, IRin, Gra, Rout, CONin, Yin, Cout, ADD,
            c2, illegal_op, taken_cnt, not_taken_cnt};
  endfunction

  function automatic void check(input string name, input vec_t act, input vec_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got st=%0d ctl=%h c2=%b ill=%b tk=%h nt=%h, want st=%0d ctl=%h c2=%b ill=%b tk=%h nt=%h",
               name, act[53:51], act[50:35], act[34:33], act[32], act[31:16], act[15:0],
               exp[53:51], exp[50:35], exp[34:33], exp[32], exp[31:16], exp[15:0]);
    end
  endfunction

  function automatic vec_t expect_vec(input logic [2:0] st, input logic [15:0] ctl,
                                      input logic [31:0] ir, input logic ill);
    return {st, ctl, ir[20:19], ill, 16'(m_tk), 16'(m_nt)};
  endfunction

  // Monitor: one expected vector per cycle, compared away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) check("cycle", actual(), sb.pop_front());
  end

  // Drive one cycle's inputs (called just after a rising edge), record
  // what the outputs must be during that cycle, then advance.
  task automatic cyc(input logic r, input logic mr, input logic cn, input logic [31:0] ir,
                     input logic [2:0] st, input logic [15:0] ctl, input logic ill);
    run = r; mem_ready = mr; CON = cn; IR = ir;
    sb.push_back(expect_vec(st, ctl, ir, ill));
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: optional idle T0 cycles, then the full step trace.
  // abort_t4 asserts clr partway through T4 instead of finishing.
  task automatic run_instr(input logic [31:0] ir, input int stalls, input logic con,
                           input int idle, input bit abort_t4);
    logic is_br;
    is_br = (ir[31:27] == BR);
    for (int i = 0; i < idle; i++) cyc(1'b0, rb(), rb(), ir, 3'd0, 16'h0, 1'b0);
    cyc(1'b1, rb(), rb(), ir, 3'd0, S_T0, 1'b0);
    for (int s = 0; s < stalls; s++)
      cyc(rb(), 1'b0, rb(), ir, 3'd1, (s == 0) ? (S_T1 | S_PCIN) : S_T1, 1'b0);
    cyc(rb(), 1'b1, rb(), ir, 3'd1, (stalls == 0) ? (S_T1 | S_PCIN) : S_T1, 1'b0);
    cyc(rb(), rb(), rb(), ir, 3'd2, S_T2, 1'b0);
    if (!is_br) begin
      cyc(rb(), rb(), rb(), ir, 3'd3, 16'h0, 1'b1);
      return;
    end
    cyc(rb(), rb(), rb(), ir, 3'd3, S_T3, 1'b0);
    if (abort_t4) begin
      run = 1'b1; mem_ready = 1'b1; CON = 1'b1;
      #1 check("in_t4", actual(), expect_vec(3'd4, S_T4, ir, 1'b0));
      clr = 1'b1;
      m_tk = 0; m_nt = 0;
      #1 check("clr_mid_t4", actual(), expect_vec(3'd0, 16'h0, ir, 1'b0));
      @(posedge clk); #1;
      cyc(1'b1, 1'b1, 1'b1, ir, 3'd0, 16'h0, 1'b0);
      clr = 1'b0;
      return;
    end
    cyc(rb(), rb(), rb(), ir, 3'd4, S_T4, 1'b0);
    cyc(rb(), rb(), rb(), ir, 3'd5, S_T5, 1'b0);
    cyc(rb(), rb(), con, ir, 3'd6, con ? (S_T6 | S_PCIN) : S_T6, 1'b0);
    if (con) m_tk = (m_tk < 65535) ? m_tk + 1 : m_tk;
    else     m_nt = (m_nt < 65535) ? m_nt + 1 : m_nt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    // Reset held with run high: step 0, every strobe low, counters zero.
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b1, 32'h9000_0000, 3'd0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h9000_0000, 3'd0, 16'h0, 1'b0);
    clr = 1'b0;

    run_instr(32'h9000_0000, 0, 1'b1, 1, 1'b0);  // taken
    run_instr(32'h9000_0000, 0, 1'b0, 0, 1'b0);  // not taken, c2 = 00
    run_instr(32'h9018_0000, 3, 1'b1, 2, 1'b0);  // three-cycle memory stall, c2 = 11
    run_instr(32'h0800_0000, 0, 1'b0, 0, 1'b0);  // illegal opcode
    run_instr(32'h9008_1234, 1, 1'b1, 0, 1'b1);  // reset during T4

    for (int n = 0; n < 40; n++) begin
      if (rb()) op = BR;
      else begin
        op = 5'($urandom_range(0, 31));
        if (op == BR) op = 5'b00000;
      end
      ir = {op, 27'($urandom)};
      run_instr(ir, $urandom_range(0, 3), rb(), $urandom_range(0, 2), 1'b0);
    end

    // Saturation: preload the taken counter just below its ceiling.
    run = 1'b0;
    force dut.u_taken.count = 16'hFFFE;
    #1 release dut.u_taken.count;
    m_tk = 16'hFFFE;
    for (int n = 0; n < 3; n++) run_instr(32'h9010_0000, 0, 1'b1, 1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 16'h0, 1'b0);

    @(negedge clk); #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
